// File: rtl/gaussian_pyramid_pkg.sv
// Shared types and default geometry for the Gaussian pyramid reader.
// Header beats are built only when PYRAMID_STREAM_HEADER_EN is defined.
package gaussian_pyramid_pkg;

    localparam int WIDTH      = 128;
    localparam int HEIGHT     = 128;
    localparam int BIT_DEPTH  = 8;
    localparam int OCTAVES    = 4;
    localparam int SCALES     = 5;
    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [BIT_DEPTH-1:0] pixel;
        logic [7:0]           x;
        logic [7:0]           y;
        logic [1:0]           octave;
        logic [2:0]           scale;
        logic                 sof;
        logic                 eof;
        logic                 header;
    } beat_t;

    // Pixel count of the whole stored pyramid; sizes the BRAM address.
    function automatic int total_pixels(int w, int h, int oct, int sc);
        int sum;
        sum = 0;
        for (int o = 0; o < oct; o++) begin
            sum += sc * (w >> o) * (h >> o);
        end
        return sum;
    endfunction

endpackage

// File: rtl/pyramid_skid_fifo.sv
// 4-deep synchronous FIFO of beat structs; the head is visible on rdata
// whenever count is non-zero.
module pyramid_skid_fifo
    import gaussian_pyramid_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  beat_t      wdata,
    input  logic       pop,
    output beat_t      rdata,
    output logic [2:0] count
);

    beat_t      mem [FIFO_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop && (count != 3'd0);
    assign do_push = push && ((count != 3'(FIFO_DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + 3'(do_push) - 3'(do_pop);
        end
    end

endmodule

// File: rtl/gaussian_pyramid_reader.sv
// Streams a stored Gaussian pyramid out of BRAM in octave/scale/raster order.
// Define PYRAMID_STREAM_HEADER_EN to emit one header beat ahead of every image.
module gaussian_pyramid_reader #(
    parameter int WIDTH   = gaussian_pyramid_pkg::WIDTH,
    parameter int HEIGHT  = gaussian_pyramid_pkg::HEIGHT,
    parameter int OCTAVES = gaussian_pyramid_pkg::OCTAVES,
    parameter int SCALES  = gaussian_pyramid_pkg::SCALES,
    parameter int ADDR_W  = $clog2(gaussian_pyramid_pkg::total_pixels(WIDTH, HEIGHT, OCTAVES, SCALES))
) (
    input  logic                                   clk_in,
    input  logic                                   rst_in,
    input  logic                                   start_in,
    output logic [ADDR_W-1:0]                      bram_addr_out,
    output logic                                   bram_en_out,
    input  logic [gaussian_pyramid_pkg::BIT_DEPTH-1:0] bram_data_in,
    output logic [gaussian_pyramid_pkg::BIT_DEPTH-1:0] pixel_out,
    output logic [7:0]                             pixel_x_out,
    output logic [7:0]                             pixel_y_out,
    output logic [1:0]                             octave_out,
    output logic [2:0]                             scale_out,
    output logic                                   sof_out,
    output logic                                   eof_out,
    output logic                                   header_out,
    output logic                                   valid_out,
    input  logic                                   ready_in,
    output logic                                   done_out,
    output logic                                   busy_out
);

    import gaussian_pyramid_pkg::*;

`ifdef PYRAMID_STREAM_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        x;
    logic [7:0]        y;
    logic [2:0]        scale;
    logic [1:0]        octave;
    logic              hdr_pending;
    logic              x_last, y_last, scale_last, octave_last, all_last;
    logic              credit, issue, issue_pix, issue_hdr, pop;
    logic              done_next;
    beat_t             issue_beat, p1, p2, wr_beat, head;
    logic              p1_v, p2_v;
    logic [2:0]        count;

    always_comb begin
        x_last      = (int'(x) == (WIDTH >> octave) - 1);
        y_last      = (int'(y) == (HEIGHT >> octave) - 1);
        scale_last  = (int'(scale) == SCALES - 1);
        octave_last = (int'(octave) == OCTAVES - 1);
        all_last    = x_last && y_last && scale_last && octave_last;
    end

    // Reads in the 2-stage pipe already own a FIFO slot, so the FIFO cannot overflow.
    assign credit    = ({1'b0, count} + 4'(p1_v) + 4'(p2_v)) < 4'(FIFO_DEPTH);
    assign issue     = (state == ST_RUN) && credit;
    assign issue_hdr = issue && hdr_pending;
    assign issue_pix = issue && !hdr_pending;
    assign pop       = valid_out && ready_in;

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            ST_IDLE:  if (start_in) state_next = ST_RUN;
            ST_RUN:   if (issue_pix && all_last) state_next = ST_DRAIN;
            ST_DRAIN: begin
                if (!p1_v && !p2_v && (count == 3'd1) && pop) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= ST_IDLE;
            done_out <= 1'b0;
        end else begin
            state    <= state_next;
            done_out <= done_next;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr        <= '0;
            x           <= 8'd0;
            y           <= 8'd0;
            scale       <= 3'd0;
            octave      <= 2'd0;
            hdr_pending <= 1'b0;
        end else if ((state == ST_IDLE) && start_in) begin
            addr        <= '0;
            x           <= 8'd0;
            y           <= 8'd0;
            scale       <= 3'd0;
            octave      <= 2'd0;
            hdr_pending <= HDR_EN;
        end else if (issue_hdr) begin
            hdr_pending <= 1'b0;
        end else if (issue_pix && !all_last) begin
            addr <= addr + ADDR_W'(1);
            if (!x_last) begin
                x <= x + 8'd1;
            end else begin
                x <= 8'd0;
                if (!y_last) begin
                    y <= y + 8'd1;
                end else begin
                    y           <= 8'd0;
                    hdr_pending <= HDR_EN;
                    if (!scale_last) begin
                        scale <= scale + 3'd1;
                    end else begin
                        scale  <= 3'd0;
                        octave <= octave + 2'd1;
                    end
                end
            end
        end
    end

    always_comb begin
        issue_beat        = '0;
        issue_beat.x      = x;
        issue_beat.y      = y;
        issue_beat.octave = octave;
        issue_beat.scale  = scale;
        issue_beat.sof    = !hdr_pending && (x == 8'd0) && (y == 8'd0);
        issue_beat.eof    = !hdr_pending && x_last && y_last;
        issue_beat.header = hdr_pending;
    end

    // Metadata rides alongside the read so it meets the BRAM data at the FIFO.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            p1_v <= 1'b0;
            p2_v <= 1'b0;
            p1   <= '0;
            p2   <= '0;
        end else begin
            p1_v <= issue;
            p1   <= issue_beat;
            p2_v <= p1_v;
            p2   <= p1;
        end
    end

    always_comb begin
        wr_beat       = p2;
        wr_beat.pixel = p2.header ? BIT_DEPTH'({2'b00, p2.octave, 1'b0, p2.scale}) : bram_data_in;
    end

    pyramid_skid_fifo u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .push  (p2_v),
        .wdata (wr_beat),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    assign valid_out     = (count != 3'd0);
    assign pixel_out     = valid_out ? head.pixel  : '0;
    assign pixel_x_out   = valid_out ? head.x      : 8'd0;
    assign pixel_y_out   = valid_out ? head.y      : 8'd0;
    assign octave_out    = valid_out ? head.octave : 2'd0;
    assign scale_out     = valid_out ? head.scale  : 3'd0;
    assign sof_out       = valid_out && head.sof;
    assign eof_out       = valid_out && head.eof;
    assign header_out    = HDR_EN && valid_out && head.header;
    assign bram_en_out   = issue_pix;
    assign bram_addr_out = issue_pix ? addr : '0;
    assign busy_out      = (state != ST_IDLE);

endmodule

// File: tb/tb_gaussian_pyramid_reader.sv
// Directed bench for gaussian_pyramid_reader on an 8x8, 2-octave, 2-scale pyramid.
// Build with PYRAMID_STREAM_HEADER_EN to check the header-beat variant.
module tb_gaussian_pyramid_reader;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int OC = 2;
    localparam int SC = 2;
    localparam int AW = 8;
    localparam int BW = 32;
`ifdef PYRAMID_STREAM_HEADER_EN
    localparam int NBEATS = 164;
`else
    localparam int NBEATS = 160;
`endif

    logic          clk = 1'b0;
    logic          rst_in = 1'b1;
    logic          start_in = 1'b0;
    logic          ready_in = 1'b0;
    logic [AW-1:0] bram_addr;
    logic          bram_en;
    logic [7:0]    bram_s1 = 8'd0;
    logic [7:0]    bram_data = 8'd0;
    logic [7:0]    pixel;
    logic [7:0]    px, py;
    logic [1:0]    oct;
    logic [2:0]    scl;
    logic          sof, eof, hdr, valid_out, done_out, busy_out;
    logic [BW-1:0] obs;
    logic [43:0]   all_out;

    int tests = 0;
    int fails = 0;
    logic [BW-1:0] exp_q[$];

    gaussian_pyramid_reader #(
        .WIDTH(W), .HEIGHT(H), .OCTAVES(OC), .SCALES(SC)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .start_in(start_in),
        .bram_addr_out(bram_addr), .bram_en_out(bram_en), .bram_data_in(bram_data),
        .pixel_out(pixel), .pixel_x_out(px), .pixel_y_out(py),
        .octave_out(oct), .scale_out(scl), .sof_out(sof), .eof_out(eof),
        .header_out(hdr), .valid_out(valid_out), .ready_in(ready_in),
        .done_out(done_out), .busy_out(busy_out)
    );

    always #5 clk = ~clk;

    // BRAM with 2-cycle read latency, mem[a] = a[7:0]
    always @(posedge clk) begin
        if (bram_en) bram_s1 <= bram_addr;
        bram_data <= bram_s1;
    end

    assign obs     = {pixel, px, py, oct, scl, sof, eof, hdr};
    assign all_out = {bram_addr, bram_en, obs, valid_out, done_out, busy_out};

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic build_expected;
        int a;
        a = 0;
        exp_q.delete();
        for (int o = 0; o < OC; o++) begin
            for (int s = 0; s < SC; s++) begin
`ifdef PYRAMID_STREAM_HEADER_EN
                exp_q.push_back({4'(o), 4'(s), 8'd0, 8'd0, 2'(o), 3'(s), 1'b0, 1'b0, 1'b1});
`endif
                for (int yy = 0; yy < (H >> o); yy++) begin
                    for (int xx = 0; xx < (W >> o); xx++) begin
                        exp_q.push_back({8'(a), 8'(xx), 8'(yy), 2'(o), 3'(s),
                                         (xx == 0 && yy == 0),
                                         (xx == (W >> o) - 1 && yy == (H >> o) - 1), 1'b0});
                        a++;
                    end
                end
            end
        end
    endtask

    task automatic test_reset;
        int busy_seen;
        busy_seen = 0;
        rst_in = 1'b1; start_in = 1'b0; ready_in = 1'b0;
        repeat (3) tick();
        rst_in = 1'b0;
        tests++;
        if (all_out !== 44'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        ready_in = 1'b1;
        repeat (20) begin
            tick();
            if (bram_en || valid_out || busy_out) busy_seen++;
        end
        tests++;
        if (busy_seen !== 0) begin
            fails++;
            $display("FAIL reset_quiet: %0d active cycles, expected 0", busy_seen);
        end
        ready_in = 1'b0;
    endtask

    task automatic test_full_rate;
        int cyc, first_valid, bubbles, accepted, done_early;
        logic [BW-1:0] e;
        build_expected();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
`ifndef PYRAMID_STREAM_HEADER_EN
        tests++;
        if ({bram_en, bram_addr} !== {1'b1, 8'd0}) begin
            fails++;
            $display("FAIL first_issue: en/addr %b/%0d expected 1/0", bram_en, bram_addr);
        end
`endif
        ready_in = 1'b1;
        cyc = 1; first_valid = 0; bubbles = 0; accepted = 0; done_early = 0;
        while (accepted < NBEATS && cyc < 1000) begin
            if (done_out) done_early++;
            if (valid_out) begin
                if (first_valid == 0) first_valid = cyc;
                e = exp_q.pop_front();
                tests++;
                if (obs !== e) begin
                    fails++;
                    $display("FAIL full_rate_beat%0d: got %h expected %h", accepted, obs, e);
                end
                accepted++;
            end else if (first_valid != 0) begin
                bubbles++;
            end
            tick();
            cyc++;
        end
        tests++;
        if (first_valid !== 4) begin
            fails++;
            $display("FAIL first_valid_cycle: got %0d expected 4", first_valid);
        end
        tests++;
        if (bubbles !== 0 || accepted !== NBEATS || done_early !== 0) begin
            fails++;
            $display("FAIL full_rate_stream: bubbles %0d beats %0d early_done %0d expected 0/%0d/0",
                     bubbles, accepted, done_early, NBEATS);
        end
        tests++;
        if ({done_out, busy_out, valid_out} !== 3'b100) begin
            fails++;
            $display("FAIL done_pulse: done/busy/valid %b expected 100", {done_out, busy_out, valid_out});
        end
        tick();
        tests++;
        if (done_out !== 1'b0) begin
            fails++;
            $display("FAIL done_width: done %b expected 0", done_out);
        end
        ready_in = 1'b0;
    endtask

    task automatic test_random_ready;
        int cyc, accepted;
        logic prev_stall;
        logic [BW-1:0] prev_obs, e;
        build_expected();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        cyc = 1; accepted = 0; prev_stall = 1'b0; prev_obs = '0;
        while (accepted < NBEATS && cyc < 3000) begin
            ready_in = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) begin
                tests++;
                if (!valid_out || obs !== prev_obs) begin
                    fails++;
                    $display("FAIL stall_hold: valid %b beat %h expected 1 %h", valid_out, obs, prev_obs);
                end
            end
            if (valid_out && ready_in) begin
                e = exp_q.pop_front();
                tests++;
                if (obs !== e) begin
                    fails++;
                    $display("FAIL random_beat%0d: got %h expected %h", accepted, obs, e);
                end
                accepted++;
            end
            prev_stall = valid_out && !ready_in;
            prev_obs   = obs;
            tick();
            cyc++;
        end
        tests++;
        if (accepted !== NBEATS || done_out !== 1'b1 || busy_out !== 1'b0) begin
            fails++;
            $display("FAIL random_end: beats %0d done %b busy %b expected %0d 1 0",
                     accepted, done_out, busy_out, NBEATS);
        end
        ready_in = 1'b0;
    endtask

    task automatic test_stall;
        int cyc, accepted, issued, stall_cyc, late_en, hold_err;
        logic [BW-1:0] hold_obs, e;
        build_expected();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        cyc = 1; accepted = 0; issued = 0; stall_cyc = 0; late_en = 0; hold_err = 0;
        hold_obs = '0;
        while (accepted < NBEATS && cyc < 1000) begin
            if (bram_en) issued++;
            if (accepted == 40 && stall_cyc < 20) begin
                ready_in = 1'b0;
                if (stall_cyc == 0) hold_obs = obs;
                else if (!valid_out || obs !== hold_obs) hold_err++;
                if (stall_cyc >= 10 && bram_en) late_en++;
                stall_cyc++;
                if (stall_cyc == 20) begin
                    tests++;
                    if (issued - 40 > 4) begin
                        fails++;
                        $display("FAIL stall_credit: %0d reads beyond accepted, expected <=4", issued - 40);
                    end
                    tests++;
                    if (late_en !== 0 || hold_err !== 0) begin
                        fails++;
                        $display("FAIL stall_quiet: late_en %0d hold_err %0d expected 0 0", late_en, hold_err);
                    end
                end
            end else begin
                ready_in = 1'b1;
                if (valid_out) begin
                    e = exp_q.pop_front();
                    tests++;
                    if (obs !== e) begin
                        fails++;
                        $display("FAIL stall_beat%0d: got %h expected %h", accepted, obs, e);
                    end
                    accepted++;
                end
            end
            tick();
            cyc++;
        end
        tests++;
        if (accepted !== NBEATS || done_out !== 1'b1) begin
            fails++;
            $display("FAIL stall_end: beats %0d done %b expected %0d 1", accepted, done_out, NBEATS);
        end
        ready_in = 1'b0;
    endtask

    task automatic test_restart;
        int cyc, accepted;
        logic [BW-1:0] e;
        build_expected();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        ready_in = 1'b1;
        cyc = 1; accepted = 0;
        while (accepted < 50 && cyc < 1000) begin
            start_in = (cyc == 10);
            if (valid_out) begin
                e = exp_q.pop_front();
                tests++;
                if (obs !== e) begin
                    fails++;
                    $display("FAIL restart_pre_beat%0d: got %h expected %h", accepted, obs, e);
                end
                accepted++;
            end
            tick();
            cyc++;
        end
        start_in = 1'b0;
        rst_in = 1'b1;
        tick();
        tests++;
        if (all_out !== 44'd0) begin
            fails++;
            $display("FAIL midrun_reset: got %h expected 0", all_out);
        end
        rst_in = 1'b0;
        repeat (3) tick();
        build_expected();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
`ifndef PYRAMID_STREAM_HEADER_EN
        tests++;
        if ({bram_en, bram_addr} !== {1'b1, 8'd0}) begin
            fails++;
            $display("FAIL restart_issue: en/addr %b/%0d expected 1/0", bram_en, bram_addr);
        end
`endif
        cyc = 1; accepted = 0;
        while (accepted < NBEATS && cyc < 1000) begin
            if (valid_out) begin
                e = exp_q.pop_front();
                tests++;
                if (obs !== e) begin
                    fails++;
                    $display("FAIL restart_beat%0d: got %h expected %h", accepted, obs, e);
                end
                accepted++;
            end
            tick();
            cyc++;
        end
        tests++;
        if (accepted !== NBEATS || done_out !== 1'b1) begin
            fails++;
            $display("FAIL restart_end: beats %0d done %b expected %0d 1", accepted, done_out, NBEATS);
        end
        ready_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_rate();
        repeat (3) tick();
        test_random_ready();
        repeat (3) tick();
        test_stall();
        repeat (3) tick();
        test_restart();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
